// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a window of 2^LEN_LOG2 valid
// samples and returns the scaled, saturated WIDTH-bit estimate with a done pulse.
module sc_stream_decoder #(
  parameter int WIDTH    = 8,
  parameter int LEN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic [LEN_LOG2:0]   samples
);

  localparam int CW = LEN_LOG2 + 1;
  localparam int SW = WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LEN_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   samples_q, samples_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CW-1:0]   ones_final;
  logic [SW-1:0]   scaled;
  logic            last_sample;

  always_comb begin
    ones_final  = ones_q + CW'(bit_in);
    scaled      = SW'(ones_final) << (WIDTH - LEN_LOG2);
    last_sample = (state_q == S_RUN) && bit_valid && (samples_q == LAST);

    state_d   = state_q;
    ones_d    = ones_q;
    samples_d = samples_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          ones_d    = '0;
          samples_d = '0;
        end
      end
      S_RUN: begin
        // Completion wins over a coincident start.
        if (last_sample) begin
          state_d   = S_DONE;
          ones_d    = '0;
          samples_d = '0;
          result_d  = scaled[WIDTH] ? {WIDTH{1'b1}} : scaled[WIDTH-1:0];
        end else if (start) begin
          ones_d    = '0;
          samples_d = '0;
        end else if (bit_valid) begin
          ones_d    = ones_final;
          samples_d = samples_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d   = start ? S_RUN : S_IDLE;
        ones_d    = '0;
        samples_d = '0;
      end
      default: begin
        state_d   = S_IDLE;
        ones_d    = '0;
        samples_d = '0;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ones_q    <= '0;
      samples_q <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      samples_q <= samples_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign samples = samples_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: one 256-sample instance and one 16-sample
// instance, checked every cycle against a counting reference model.
module tb_sc_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st [2];
  logic       bv [2];
  logic       bi [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [7:0] result_o [2];
  logic [8:0] samples0;
  logic [4:0] samples1;

  always #5 clk = ~clk;

  sc_stream_decoder #(.WIDTH(8), .LEN_LOG2(8)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .bit_in(bi[0]), .bit_valid(bv[0]),
    .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]), .samples(samples0)
  );

  sc_stream_decoder #(.WIDTH(8), .LEN_LOG2(4)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .bit_in(bi[1]), .bit_valid(bv[1]),
    .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]), .samples(samples1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: window state expressed as plain counts.
  int lens [2] = '{8, 4};
  int m_act [2];
  int m_done [2];
  int m_ones [2];
  int m_n [2];
  int m_res [2];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_done[d] = 0; m_ones[d] = 0; m_n[d] = 0; m_res[d] = 0;
    end
  endtask

  task automatic m_update(input int d, input logic s, input logic v, input logic b);
    int win;
    int tot;
    win = 1 << lens[d];
    m_done[d] = 0;
    if (m_act[d] != 0) begin
      if (v && (m_n[d] + 1 == win)) begin
        tot = (m_ones[d] + int'(b)) * (256 / win);
        m_res[d]  = (tot > 255) ? 255 : tot;
        m_act[d]  = 0;
        m_done[d] = 1;
        m_n[d] = 0; m_ones[d] = 0;
      end else if (s) begin
        m_n[d] = 0; m_ones[d] = 0;
      end else if (v) begin
        m_n[d]++;
        m_ones[d] += int'(b);
      end
    end else if (s) begin
      m_act[d] = 1; m_n[d] = 0; m_ones[d] = 0;
    end
  endtask

  task automatic check_all();
    int smp [2];
    smp[0] = int'(samples0);
    smp[1] = int'(samples1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d),    int'(busy_o[d]),   m_act[d]);
      chk($sformatf("done%0d", d),    int'(done_o[d]),   m_done[d]);
      chk($sformatf("result%0d", d),  int'(result_o[d]), m_res[d]);
      chk($sformatf("samples%0d", d), smp[d],            m_n[d]);
    end
  endtask

  task automatic step(input logic s0, input logic v0, input logic b0,
                      input logic s1, input logic v1, input logic b1);
    @(negedge clk);
    st[0] = s0; bv[0] = v0; bi[0] = b0;
    st[1] = s1; bv[1] = v1; bi[1] = b1;
    @(posedge clk);
    m_update(0, s0, v0, b0);
    m_update(1, s1, v1, b1);
    #1;
    check_all();
  endtask

  task automatic step0(input logic s, input logic v, input logic b);
    step(s, v, b, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic s; logic v; logic b;
    int eb; int ed; int es; int er;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int valid_cnt;
    int cyc;
    logic alt;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin st[d] = 0; bv[d] = 0; bi[d] = 0; end
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // 1: all-ones window saturates
    step0(1, 0, 0);
    for (int i = 0; i < 256; i++) step0(0, 1, 1);
    chk("t1_result_ff", int'(result_o[0]), 255);
    chk("t1_done", int'(done_o[0]), 1);
    step0(0, 1, 1);
    chk("t1_done_pulse_end", int'(done_o[0]), 0);

    // 2: all-zeros window
    step0(1, 0, 0);
    for (int i = 0; i < 256; i++) step0(0, 1, 0);
    chk("t2_result_00", int'(result_o[0]), 0);
    step0(0, 0, 0);

    // 3: alternating bits with a stall every third cycle
    step0(1, 0, 0);
    valid_cnt = 0; cyc = 0; alt = 1'b1;
    while (valid_cnt < 256 && cyc < 1000) begin
      if (cyc % 3 == 2) step0(0, 0, ~alt);
      else begin
        step0(0, 1, alt);
        alt = ~alt;
        valid_cnt++;
      end
      cyc++;
    end
    chk("t3_result_80", int'(result_o[0]), 128);
    step0(0, 0, 0);

    // 4: abort after 100 samples, then a quarter-density window
    step0(1, 0, 0);
    for (int i = 0; i < 100; i++) step0(0, 1, 1);
    step0(1, 1, 1);
    chk("t4_prior_result", int'(result_o[0]), 128);
    for (int i = 0; i < 256; i++) step0(0, 1, (i % 4) == 0);
    chk("t4_result_40", int'(result_o[0]), 64);
    step0(0, 0, 0);

    // 5: asynchronous reset mid-window
    step0(1, 0, 0);
    for (int i = 0; i < 50; i++) step0(0, 1, i[0]);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin st[d] = 0; bv[d] = 0; bi[d] = 0; end
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("t5_busy", int'(busy_o[0]), 0);
    chk("t5_result", int'(result_o[0]), 0);
    chk("t5_samples", int'(samples0), 0);
    @(negedge clk);
    rst = 1'b0;
    step0(1, 0, 0);
    for (int i = 0; i < 256; i++) step0(0, 1, 1'($urandom_range(0, 1)));

    // 6: short window on the 16-sample instance, table-driven
    tbl[0] = '{1, 0, 0, 1, 0, 0, 0};
    for (int i = 1; i <= 15; i++) tbl[i] = '{0, 1, (i <= 5), 1, 0, i, 0};
    tbl[16] = '{0, 1, 0, 0, 1, 0, 80};
    tbl[17] = '{1, 0, 0, 1, 0, 0, 80};
    tbl[18] = '{0, 1, 1, 1, 0, 1, 80};
    tbl[19] = '{1, 1, 1, 1, 0, 0, 80};
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, tbl[i].s, tbl[i].v, tbl[i].b);
      chk($sformatf("tbl%0d_busy", i),    int'(busy_o[1]),   tbl[i].eb);
      chk($sformatf("tbl%0d_done", i),    int'(done_o[1]),   tbl[i].ed);
      chk($sformatf("tbl%0d_samples", i), int'(samples1),    tbl[i].es);
      chk($sformatf("tbl%0d_result", i),  int'(result_o[1]), tbl[i].er);
    end

    // Random traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 40) == 0),  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
